// File: rtl/regfile_scoreboard_pkg.sv
// Shared constants and helpers for the scoreboarded register file.
//   DEFAULT_DATA_WIDTH : default register width in bits
//   DEFAULT_ADDR_WIDTH : default register index width
//   ZERO_IDX           : index of the optional hardwired-zero register
//   depth()            : number of registers for a given index width
package regfile_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 5;
    localparam int unsigned ZERO_IDX           = 0;

    function automatic int unsigned depth(input int unsigned addr_width);
        return 32'd1 << addr_width;
    endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Bus bundle for regfile_scoreboard (everything except clock and reset).
//   master : pipeline side, drives write/reserve/read indices, receives read data
//   slave  : register file side
interface regfile_scoreboard_if
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
);

    logic                  ctrl_writeEn;
    logic [ADDR_WIDTH-1:0] ctrl_writeReg;
    logic [DATA_WIDTH-1:0] data_writeReg;
    logic                  ctrl_reserveEn;
    logic [ADDR_WIDTH-1:0] ctrl_reserveReg;
    logic [ADDR_WIDTH-1:0] ctrl_readRegA;
    logic [ADDR_WIDTH-1:0] ctrl_readRegB;
    logic [DATA_WIDTH-1:0] data_readRegA;
    logic [DATA_WIDTH-1:0] data_readRegB;
    logic                  data_validA;
    logic                  data_validB;
    logic [ADDR_WIDTH:0]   pending_count;

    modport master (
        output ctrl_writeEn, ctrl_writeReg, data_writeReg,
        output ctrl_reserveEn, ctrl_reserveReg,
        output ctrl_readRegA, ctrl_readRegB,
        input  data_readRegA, data_readRegB, data_validA, data_validB, pending_count
    );

    modport slave (
        input  ctrl_writeEn, ctrl_writeReg, data_writeReg,
        input  ctrl_reserveEn, ctrl_reserveReg,
        input  ctrl_readRegA, ctrl_readRegB,
        output data_readRegA, data_readRegB, data_validA, data_validB, pending_count
    );

endinterface

// File: rtl/regfile_scoreboard_read_port.sv
// One combinational read port of the scoreboarded register file.
//   idx_i               : register index to read
//   regs_i / pending_i  : stored register contents and pending bits
//   wr_en_i/wr_idx_i/wr_data_i : effective same-cycle write (already gated by reset)
//   res_en_i/res_idx_i  : effective same-cycle reserve
//   data_o / valid_o    : read data; valid=1 when no producer is outstanding
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned ZERO_REG   = 1,
    parameter int unsigned BYPASS     = 1,
    parameter int unsigned DEPTH      = depth(ADDR_WIDTH)
) (
    input  logic [ADDR_WIDTH-1:0]             idx_i,
    input  logic [DEPTH-1:0][DATA_WIDTH-1:0]  regs_i,
    input  logic [DEPTH-1:0]                  pending_i,
    input  logic                              wr_en_i,
    input  logic [ADDR_WIDTH-1:0]             wr_idx_i,
    input  logic [DATA_WIDTH-1:0]             wr_data_i,
    input  logic                              res_en_i,
    input  logic [ADDR_WIDTH-1:0]             res_idx_i,
    output logic [DATA_WIDTH-1:0]             data_o,
    output logic                              valid_o
);

    always_comb begin
        data_o  = regs_i[idx_i];
        valid_o = ~pending_i[idx_i];
        if (ZERO_REG != 0 && idx_i == ADDR_WIDTH'(ZERO_IDX)) begin
            data_o  = '0;
            valid_o = 1'b1;
        end else if (BYPASS != 0 && wr_en_i && wr_idx_i == idx_i) begin
            // A reserve of the same index issues a newer producer, so the
            // forwarded data is already stale.
            data_o  = wr_data_i;
            valid_o = ~(res_en_i && res_idx_i == idx_i);
        end
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with one write port, two combinational read ports, optional
// write-to-read bypass, optional hardwired-zero register and per-register
// pending bits with a live pending counter for RAW hazard detection.
//   clock      : sole clock, all state updates on posedge
//   ctrl_reset : synchronous active-high reset
//   bus        : write/reserve/read signals, read data/valid, pending_count
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned ZERO_REG   = 1,
    parameter int unsigned BYPASS     = 1
) (
    input  logic           clock,
    input  logic           ctrl_reset,
    regfile_scoreboard_if.slave bus
);

    localparam int unsigned DEPTH = depth(ADDR_WIDTH);
    localparam int unsigned CW    = ADDR_WIDTH + 1;

    logic [DEPTH-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
    logic [DEPTH-1:0]                 pending_q, pending_d;
    logic [CW-1:0]                    count_q, count_d;

    logic wr_eff, res_eff, cnt_inc, cnt_dec;

    // Index 0 accepts nothing when it is hardwired to zero.
    assign wr_eff  = bus.ctrl_writeEn &
                     ~(ZERO_REG != 0 && bus.ctrl_writeReg == ADDR_WIDTH'(ZERO_IDX));
    assign res_eff = bus.ctrl_reserveEn &
                     ~(ZERO_REG != 0 && bus.ctrl_reserveReg == ADDR_WIDTH'(ZERO_IDX));

    // Count tracks popcount(pending) incrementally: a reserve adds only when
    // the bit was clear, a write retires only when set and not re-reserved.
    assign cnt_inc = res_eff & ~pending_q[bus.ctrl_reserveReg];
    assign cnt_dec = wr_eff & pending_q[bus.ctrl_writeReg] &
                     ~(res_eff && bus.ctrl_reserveReg == bus.ctrl_writeReg);

    always_comb begin
        regs_d    = regs_q;
        pending_d = pending_q;
        count_d   = count_q + CW'(cnt_inc) - CW'(cnt_dec);
        if (wr_eff) begin
            regs_d[bus.ctrl_writeReg]    = bus.data_writeReg;
            pending_d[bus.ctrl_writeReg] = 1'b0;
        end
        // Applied after the write so a same-index reserve wins.
        if (res_eff) begin
            pending_d[bus.ctrl_reserveReg] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            regs_q    <= '0;
            pending_q <= '0;
            count_q   <= '0;
        end else begin
            regs_q    <= regs_d;
            pending_q <= pending_d;
            count_q   <= count_d;
        end
    end

    assign bus.pending_count = count_q;

    // No forwarding while reset is held: reads show stored state only.
    logic byp_wr_en, byp_res_en;
    assign byp_wr_en  = wr_eff & ~ctrl_reset;
    assign byp_res_en = res_eff & ~ctrl_reset;

    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG),
        .BYPASS     (BYPASS),
        .DEPTH      (DEPTH)
    ) u_port_a (
        .idx_i     (bus.ctrl_readRegA),
        .regs_i    (regs_q),
        .pending_i (pending_q),
        .wr_en_i   (byp_wr_en),
        .wr_idx_i  (bus.ctrl_writeReg),
        .wr_data_i (bus.data_writeReg),
        .res_en_i  (byp_res_en),
        .res_idx_i (bus.ctrl_reserveReg),
        .data_o    (bus.data_readRegA),
        .valid_o   (bus.data_validA)
    );

    regfile_read_port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .ZERO_REG   (ZERO_REG),
        .BYPASS     (BYPASS),
        .DEPTH      (DEPTH)
    ) u_port_b (
        .idx_i     (bus.ctrl_readRegB),
        .regs_i    (regs_q),
        .pending_i (pending_q),
        .wr_en_i   (byp_wr_en),
        .wr_idx_i  (bus.ctrl_writeReg),
        .wr_data_i (bus.data_writeReg),
        .res_en_i  (byp_res_en),
        .res_idx_i (bus.ctrl_reserveReg),
        .data_o    (bus.data_readRegB),
        .valid_o   (bus.data_validB)
    );

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the processor register file: DEPTH = 2**ADDR_WIDTH registers of DATA_WIDTH bits.
- One write port and two combinational read ports.
- Optional write-to-read bypass and optional hardwired-zero register 0.
- Per-register pending (scoreboard) bits with a live pending counter, so the pipeline can detect RAW hazards without a separate scoreboard block.

Parameters:
- DATA_WIDTH, 32, register width in bits.
- ADDR_WIDTH, 5, register index width; DEPTH = 2**ADDR_WIDTH.
- ZERO_REG, 1, when 1 register 0 reads 0, ignores writes and never becomes pending.
- BYPASS, 1, when 1 same-cycle write data is forwarded to a read port addressing the written register.

Ports:
- clock  input  1  sole clock; all state updates on posedge.
- ctrl_reset  input  1  synchronous, active-high reset.
- ctrl_writeEn  input  1  write strobe; also retires the pending bit of ctrl_writeReg.
- ctrl_writeReg  input  ADDR_WIDTH  write index.
- data_writeReg  input  DATA_WIDTH  write data.
- ctrl_reserveEn  input  1  marks ctrl_reserveReg pending (producer issued).
- ctrl_reserveReg  input  ADDR_WIDTH  reserve index.
- ctrl_readRegA  input  ADDR_WIDTH  port A index.
- ctrl_readRegB  input  ADDR_WIDTH  port B index.
- data_readRegA  output  DATA_WIDTH  port A data (combinational).
- data_readRegB  output  DATA_WIDTH  port B data (combinational).
- data_validA  output  1  1 = port A data is not awaiting a producer.
- data_validB  output  1  1 = port B data is not awaiting a producer.
- pending_count  output  ADDR_WIDTH+1  number of registers currently pending.

Behaviour:
- Reset: on a posedge with ctrl_reset=1, all registers become 0, all pending bits 0 and pending_count 0. Write and reserve inputs are ignored that cycle. After reset, reads return 0 with valid=1.
- Write: on a posedge with ctrl_writeEn=1, reg[ctrl_writeReg] <= data_writeReg and pending[ctrl_writeReg] <= 0. The write is visible on read ports combinationally from the next cycle.
- Reserve: on a posedge with ctrl_reserveEn=1, pending[ctrl_reserveReg] <= 1. Reserving an already-pending register leaves it pending and does not change the count.
- Same-register write and reserve in one cycle: reserve wins. The data is written, pending stays or becomes 1. This models an older producer retiring while a newer one issues.
- Different-register write and reserve in one cycle: both take effect.
- Writing a non-pending register: data is written, pending stays 0, count unchanged (no underflow).
- pending_count: registered; always equals popcount(pending). Per cycle it changes by +1, -1 or 0. Its range is 0..DEPTH (0..DEPTH-1 when ZERO_REG=1).
- ZERO_REG=1, index 0: writes to index 0 are dropped, reserves to index 0 are dropped, and reads of index 0 return 0 with valid=1.
- Read, BYPASS=0: data = reg[idx]; valid = ~pending[idx].
- Read, BYPASS=1, when ctrl_writeEn=1 and ctrl_writeReg == idx (and idx ≠ 0 if ZERO_REG):
  - data = data_writeReg;
  - valid = ~(ctrl_reserveEn && ctrl_reserveReg == idx).
- Read, BYPASS=1, otherwise: same as BYPASS=0.
- Ports A and B are fully independent and may address the same register.
- While ctrl_reset=1, read outputs reflect stored state. No bypass is applied during reset.
- Latency: write-to-read is 0 cycles with BYPASS=1, 1 cycle without. Reserve-to-invalid is 1 cycle (read valid deasserts after the reserving edge).

Decomposition:
- Shared package regfile_pkg holds:
  - default DATA_WIDTH / ADDR_WIDTH constants;
  - a function computing the DEPTH from ADDR_WIDTH;
  - the ZERO_IDX constant.
- One natural sub-module, regfile_read_port, is instantiated twice. It takes the index, the storage vector, the pending vector and the write/reserve bypass signals, and produces data and valid.
- Storage, pending vector and counter stay in the top module.

Test Plan:
- Reset, then read all 32 indices on both ports -> data 0, valid 1, pending_count 0.
- Write 32'h0000DEAD to index 0 (ZERO_REG=1), read index 0 next cycle -> 32'h0 valid 1. Write 32'h0000DEAD to each index 1..31, read each next cycle -> 32'h0000DEAD on A and B.
- Reserve index 7 -> next cycle validA=0 for index 7 and pending_count=1. Write 32'h12345678 to index 7 while port A reads 7 (BYPASS=1) -> same cycle data 32'h12345678, validA=1. Next cycle pending_count=0.
- Same cycle: reserve 9 and write 32'hCAFEBABE to 9, with 9 previously pending -> same cycle data 32'hCAFEBABE, valid 0. Next cycle pending_count still 1 and data_readRegA=32'hCAFEBABE, validA=0.
- Reserve indices 1..31 one per cycle -> pending_count 31. Re-reserve index 5 -> stays 31. Write index 12 while reserving 3 again -> 30. Assert ctrl_reset mid-sequence -> next cycle count 0, all data 0.
- BYPASS=0 instance: write 32'hA5A5A5A5 to index 4 while reading 4 -> old value 32'h0 this cycle, 32'hA5A5A5A5 next cycle.
